// File: rtl/mean_pkg.sv
// Shared state encoding and default sizing for the mean sequencer.
package mean_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_N_SAMPLES = 6;
  localparam int COUNT_W           = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: WIDTH iterations, one quotient bit per clock.
// A start pulse loads the operands; done pulses for one cycle after the last bit.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;

  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    // Borrow out of the trial subtraction means the divisor did not fit.
    trial   = partial - {1'b0, divisor};
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      cnt_d  = CNT_W'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = partial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mean_sequencer.sv
// Accumulates N_SAMPLES unsigned samples and presents sum / N_SAMPLES with remainder.
// Define MEAN_ROUND_EN to round the mean to nearest instead of truncating.
module mean_sequencer
  import mean_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mean,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   mean_q, mean_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic               accept;
  logic               last_sample;
  logic               frame_ovf;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   rounded_mean;

  assign in_ready    = (state_q == ACCUM) && !rst;
  assign out_valid   = (state_q == HOLD);
  assign accept      = in_valid && in_ready;
  assign sum_ext     = {1'b0, sum_q} + {1'b0, in_data};
  assign last_sample = (count_q == COUNT_W'(N_SAMPLES - 1));
  assign frame_ovf   = ovf_q | sum_ext[WIDTH];
  // The divider loads the final sum on the same edge that accepts the last sample.
  assign div_start   = accept && last_sample && !frame_ovf;

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sum_ext[WIDTH-1:0]),
    .divisor  (WIDTH'(N_SAMPLES)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

`ifdef MEAN_ROUND_EN
  localparam logic [WIDTH:0] N_EXT = (WIDTH + 1)'(N_SAMPLES);
  assign rounded_mean = ({div_rem, 1'b0} >= N_EXT) ? div_quo + WIDTH'(1) : div_quo;
`else
  assign rounded_mean = div_quo;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mean_d  = mean_q;
    rem_d   = rem_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          sum_d   = sum_ext[WIDTH-1:0];
          count_d = count_q + COUNT_W'(1);
          ovf_d   = frame_ovf;
          if (last_sample) begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        // An overflowed frame skips the divider and reports zeros one edge later.
        if (ovf_q) begin
          state_d = HOLD;
          mean_d  = '0;
          rem_d   = '0;
        end else if (div_done && !div_busy) begin
          state_d = HOLD;
          mean_d  = rounded_mean;
          rem_d   = div_rem;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          sum_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mean_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mean_q  <= mean_d;
      rem_q   <= rem_d;
    end
  end

  assign mean      = mean_q;
  assign remainder = rem_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mean_sequencer.sv
// Directed bench for mean_sequencer: frame vector table plus stall and reset-abort sequences.
module tb_mean_sequencer;

  localparam int WIDTH = 32;
  localparam int N     = 6;
`ifdef MEAN_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] mean;
  logic [WIDTH-1:0] remainder;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mean_sequencer #(
    .WIDTH    (WIDTH),
    .N_SAMPLES(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mean     (mean),
    .remainder(remainder),
    .overflow (overflow)
  );

  typedef struct {
    logic [N-1:0][WIDTH-1:0] samples;
    bit                      gap;
    logic [WIDTH-1:0]        exp_mean;
    logic [WIDTH-1:0]        exp_rem;
    logic                    exp_ovf;
    int                      exp_lat;
  } frame_t;

  frame_t vecs [9];

  function automatic frame_t mk(input logic [WIDTH-1:0] a, b, c, d, e, f, input bit gap,
                                input logic [WIDTH-1:0] m, r, input logic o, input int lat);
    frame_t v;
    v.samples[0] = a; v.samples[1] = b; v.samples[2] = c;
    v.samples[3] = d; v.samples[4] = e; v.samples[5] = f;
    v.gap = gap; v.exp_mean = m; v.exp_rem = r; v.exp_ovf = o; v.exp_lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic sendSample(input logic [WIDTH-1:0] data, input bit gap);
    int waited = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = data;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input frame_t v, input int idx);
    int lat = 0;
    for (int i = 0; i < N; i++) sendSample(v.samples[i], v.gap);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("v%0d latency", idx), WIDTH'(lat), WIDTH'(v.exp_lat));
    checkOutput($sformatf("v%0d mean", idx), mean, v.exp_mean);
    checkOutput($sformatf("v%0d remainder", idx), remainder, v.exp_rem);
    checkOutput($sformatf("v%0d overflow", idx), WIDTH'(overflow), WIDTH'(v.exp_ovf));
    releaseResult();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stray;

    vecs[0] = mk(10, 20, 30, 40, 50, 60, 1'b0, 35, 0, 1'b0, WIDTH + 1);
    vecs[1] = mk(0, 0, 0, 0, 0, 5, 1'b0, ROUND ? 1 : 0, 5, 1'b0, WIDTH + 1);
    vecs[2] = mk(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 1);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, WIDTH + 1);
    vecs[4] = mk(1, 1, 1, 1, 1, 2, 1'b1, 1, 1, 1'b0, WIDTH + 1);
    vecs[5] = mk(32'hFFFF_FFF0, 32'hF, 0, 0, 0, 0, 1'b0,
                 ROUND ? 715827883 : 715827882, 3, 1'b0, WIDTH + 1);
    vecs[6] = mk(32'h8000_0000, 32'h8000_0000, 5, 5, 5, 5, 1'b0, 0, 0, 1'b1, 1);
    vecs[7] = mk(100, 101, 102, 103, 104, 105, 1'b0, ROUND ? 103 : 102, 3, 1'b0, WIDTH + 1);
    vecs[8] = mk(7, 7, 7, 7, 7, 7, 1'b0, 7, 0, 1'b0, WIDTH + 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", WIDTH'(in_ready), 0);
    checkOutput("reset out_valid", WIDTH'(out_valid), 0);
    checkOutput("reset mean", mean, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset overflow", WIDTH'(overflow), 0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", WIDTH'(in_ready), 1);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Stalled result: upstream keeps offering data while downstream refuses the result.
    for (int i = 0; i < N; i++) sendSample(WIDTH'((i + 1) * 10), 1'b0);
    stray = 0;
    while (!out_valid && stray < 200) begin
      @(posedge clk); #1;
      stray++;
    end
    checkOutput("stall out_valid", WIDTH'(out_valid), 1);
    in_valid = 1'b1;
    in_data  = 1000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d mean", c), mean, 35);
      checkOutput($sformatf("stall%0d remainder", c), remainder, 0);
      checkOutput($sformatf("stall%0d in_ready", c), WIDTH'(in_ready), 0);
      checkOutput($sformatf("stall%0d out_valid", c), WIDTH'(out_valid), 1);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("release in_ready", WIDTH'(in_ready), 1);
    checkOutput("release out_valid", WIDTH'(out_valid), 0);
    applyStimulus(vecs[8], 80);

    // Abort a frame five cycles into its division; its result must never appear.
    for (int i = 0; i < N; i++) sendSample(50, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort in_ready", WIDTH'(in_ready), 0);
    checkOutput("abort out_valid", WIDTH'(out_valid), 0);
    checkOutput("abort mean", mean, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort release in_ready", WIDTH'(in_ready), 1);
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    checkOutput("abort stray out_valid cycles", WIDTH'(stray), 0);
    applyStimulus(vecs[8], 81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mean_sequencer.md
MEAN_SEQUENCER -- requirements
Module: mean_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, data path width of samples, sum, mean and remainder.
REQ-002 Parameter N_SAMPLES, default 6, samples per frame; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream sample present.
REQ-006 in_data  input  WIDTH  unsigned sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  frame result present.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 mean  output  WIDTH  frame sum / N_SAMPLES (unsigned).
REQ-011 remainder  output  WIDTH  frame sum mod N_SAMPLES.
REQ-012 overflow  output  1  frame sum exceeded WIDTH bits; qualified by out_valid.

Function
REQ-013 States SHALL be ACCUM, DIVIDE, HOLD; in_ready = 1 only in ACCUM, out_valid = 1 only in HOLD.
REQ-014 Sample accepted on an edge with in_valid && in_ready; sum += in_data computed at WIDTH+1 bits, count += 1.
REQ-015 Carry out of the WIDTH-bit sum SHALL set a sticky overflow flag; accumulation of the remaining frame samples continues, sum value then don't-care.
REQ-016 On acceptance of sample number N_SAMPLES: no overflow -> DIVIDE; overflow -> HOLD with mean = 0, remainder = 0, overflow = 1.
REQ-017 DIVIDE SHALL run a restoring divider, one quotient bit per cycle, WIDTH iterations.
REQ-018 No-overflow latency: out_valid rises exactly WIDTH+1 edges after the edge accepting the last sample; overflow latency: 1 edge.
REQ-019 HOLD: mean, remainder, overflow SHALL stay stable while out_valid && !out_ready.
REQ-020 Edge with out_valid && out_ready SHALL clear sum, count, overflow flag and return to ACCUM; in_ready high the following cycle.
REQ-021 in_valid while in_ready = 0 SHALL be ignored (no sample consumed, upstream holds).
REQ-022 All-zero samples SHALL give mean = 0, remainder = 0, overflow = 0.
REQ-023 Sum exactly 2^WIDTH-1 is not overflow.

Reset
REQ-024 While rst high: state ACCUM, sum = 0, count = 0, overflow = 0, mean = 0, remainder = 0, out_valid = 0, in_ready = 0.
REQ-025 in_ready SHALL assert on the first clk cycle after rst deasserts.
REQ-026 rst asserted mid-frame, mid-DIVIDE or in HOLD SHALL abort the frame; no result is ever presented for it.

Configuration
REQ-027 Macro MEAN_ROUND_EN: defined -> mean = quotient + 1 when 2*remainder >= N_SAMPLES, else quotient; remainder output stays the raw modulus.
REQ-028 MEAN_ROUND_EN undefined -> mean = truncated quotient; latency identical in both builds.

Structure
REQ-029 Package mean_pkg SHALL hold the state enum (ACCUM, DIVIDE, HOLD) and the default WIDTH/N_SAMPLES constants.
REQ-030 Sub-module seq_divider (start, dividend, divisor, busy, done, quotient, remainder), WIDTH-cycle restoring divider, SHALL implement DIVIDE.

Verification
REQ-031 Samples 10,20,30,40,50,60 back-to-back -> mean 35, remainder 0, overflow 0, out_valid 33 edges after sixth accept.
REQ-032 Samples 0,0,0,0,0,5 -> remainder 5; mean 0 without MEAN_ROUND_EN, 1 with it.
REQ-033 Samples 0xFFFFFFFF,1,0,0,0,0 -> overflow 1, mean 0, remainder 0, out_valid 1 edge after sixth accept.
REQ-034 Result present, out_ready low 10 cycles with in_valid high -> outputs stable, in_ready 0, no sample consumed; out_ready high -> in_ready 1 next cycle.
REQ-035 rst pulsed 5 cycles into DIVIDE -> out_valid never asserts; next frame 6x7 -> mean 7, remainder 0.
REQ-036 in_valid toggling every other cycle, samples 1,1,1,1,1,2 -> mean 1, remainder 1 in both builds.
